drw_wrt_burst: RTL and testbench

- Write-back end of the draw pipeline. Drains the 32-bit pixel write FIFO filled by the pixel management stage.
- Issues AXI4 write bursts that store a WIDTH x HEIGHT pixel rectangle into the destination frame buffer.
- Handles line stepping, burst sizing and 4 KB boundary splitting, and tracks write responses up to DONE.

---
 rtl/drw_wrt_burst.sv | 250 +++++++++++++++++++++++++
 tb/tb_drw_wrt_burst.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drw_wrt_burst.sv
`default_nettype none
// ============================================================================
//  Module   : drw_wrt_burst
//  Purpose  : Draw-pipeline write-back engine. Drains the pixel write FIFO
//             into AXI4 INCR write bursts covering a WIDTH x HEIGHT rectangle,
//             splitting bursts at line ends and 4 KB boundaries and tracking
//             B responses up to DONE.
//  Options  : `define DRW_WRT_BRESP_ERRCNT_EN to count non-OKAY responses
//             on ERR_CNT (otherwise ERR_CNT is tied to zero).
//  Revision : 1.0 - initial release
// ============================================================================
module drw_wrt_burst #(
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 9
) (
  input  logic             ACLK,
  input  logic             ARST_N,
  input  logic             RST,
  input  logic             START,
  input  logic [31:0]      DST_ADDR,
  input  logic [15:0]      DST_STRIDE,
  input  logic [11:0]      WIDTH,
  input  logic [11:0]      HEIGHT,
  output logic             BUSY,
  output logic             DONE,
  output logic [7:0]       ERR_CNT,
  input  logic [CNT_W-1:0] WRT_FIFO_DATA_CNT,
  output logic             WRT_FIFO_RD,
  input  logic [31:0]      WRT_FIFO_DOUT,
  output logic [31:0]      M_AXI_AWADDR,
  output logic [7:0]       M_AXI_AWLEN,
  output logic [2:0]       M_AXI_AWSIZE,
  output logic [1:0]       M_AXI_AWBURST,
  output logic             M_AXI_AWVALID,
  input  logic             M_AXI_AWREADY,
  output logic [31:0]      M_AXI_WDATA,
  output logic [3:0]       M_AXI_WSTRB,
  output logic             M_AXI_WLAST,
  output logic             M_AXI_WVALID,
  input  logic             M_AXI_WREADY,
  input  logic [1:0]       M_AXI_BRESP,
  input  logic             M_AXI_BVALID,
  output logic             M_AXI_BREADY
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CALC  = 3'd1;
  localparam logic [2:0] S_AW    = 3'd2;
  localparam logic [2:0] S_W     = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam int          c_OUT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [12:0] c_MAX_BURST = 13'(MAX_BURST);
  localparam logic [31:0] c_MAX_OUT   = 32'(MAX_OUTSTANDING);

  logic [2:0]         r_state;
  logic [31:0]        r_addr;
  logic [31:0]        r_line_addr;
  logic [15:0]        r_stride;
  logic [11:0]        r_width;
  logic [11:0]        r_pix_left;
  logic [11:0]        r_lines_left;
  logic [8:0]         r_len;
  logic [8:0]         r_beat;
  logic [c_OUT_W-1:0] r_outstanding;
  logic               r_busy;
  logic               r_done;
  logic               r_bready;
  logic [31:0]        r_awaddr;
  logic [7:0]         r_awlen;

  logic [12:0] w_room_bytes;
  logic [12:0] w_room;
  logic [12:0] w_len;
  logic        w_can_issue;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_b_hs;
  logic        w_last_beat;
  logic        w_line_end;
  logic [31:0] w_next_line;

  // Burst length: limited by MAX_BURST, the rest of the line and the 4 KB page
  always_comb begin
    w_room_bytes = 13'd4096 - {1'b0, r_addr[11:0]};
    w_room       = w_room_bytes >> 2;
    w_len        = c_MAX_BURST;
    if ({1'b0, r_pix_left} < w_len) w_len = {1'b0, r_pix_left};
    if (w_room < w_len)             w_len = w_room;
  end

  // The whole burst must already sit in the FIFO so WVALID never gaps
  assign w_can_issue = (32'(WRT_FIFO_DATA_CNT) >= 32'(w_len)) &&
                       (32'(r_outstanding) < c_MAX_OUT);

  assign w_aw_hs     = (r_state == S_AW) && M_AXI_AWREADY;
  assign w_w_hs      = (r_state == S_W) && M_AXI_WREADY;
  assign w_b_hs      = M_AXI_BVALID && r_bready;
  assign w_last_beat = (r_beat == (r_len - 9'd1));
  assign w_line_end  = (r_pix_left == {3'b000, r_len});
  assign w_next_line = r_line_addr + {16'h0000, r_stride};

  assign BUSY          = r_busy;
  assign DONE          = r_done;
  assign WRT_FIFO_RD   = w_w_hs;
  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWLEN   = r_awlen;
  assign M_AXI_AWSIZE  = 3'b010;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWVALID = (r_state == S_AW);
  assign M_AXI_WDATA   = WRT_FIFO_DOUT;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WVALID  = (r_state == S_W);
  assign M_AXI_WLAST   = (r_state == S_W) && w_last_beat;
  assign M_AXI_BREADY  = r_bready;

  // Main sequencer: parameter latch, burst sizing, beat counting, line stepping
  always_ff @(posedge ACLK or negedge ARST_N) begin
    if (!ARST_N) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_line_addr  <= '0;
      r_stride     <= '0;
      r_width      <= '0;
      r_pix_left   <= '0;
      r_lines_left <= '0;
      r_len        <= '0;
      r_beat       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_awaddr     <= '0;
      r_awlen      <= '0;
    end else if (RST) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_line_addr  <= '0;
      r_stride     <= '0;
      r_width      <= '0;
      r_pix_left   <= '0;
      r_lines_left <= '0;
      r_len        <= '0;
      r_beat       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_awaddr     <= '0;
      r_awlen      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_addr       <= DST_ADDR;
            r_line_addr  <= DST_ADDR;
            r_stride     <= DST_STRIDE;
            r_width      <= WIDTH;
            r_pix_left   <= WIDTH;
            r_lines_left <= HEIGHT;
            r_busy       <= 1'b1;
            r_state      <= S_CALC;
          end
        end
        S_CALC: begin
          r_len <= w_len[8:0];
          if (w_can_issue) begin
            r_awaddr <= r_addr;
            r_awlen  <= 8'(w_len - 13'd1);
            r_beat   <= '0;
            r_state  <= S_AW;
          end
        end
        S_AW: begin
          if (M_AXI_AWREADY) r_state <= S_W;
        end
        S_W: begin
          if (w_w_hs) begin
            r_beat <= r_beat + 9'd1;
            if (w_last_beat) begin
              if (w_line_end) begin
                r_line_addr  <= w_next_line;
                r_addr       <= w_next_line;
                r_pix_left   <= r_width;
                r_lines_left <= r_lines_left - 12'd1;
                r_state      <= (r_lines_left == 12'd1) ? S_DRAIN : S_CALC;
              end else begin
                r_addr     <= r_addr + {21'h0, r_len, 2'b00};
                r_pix_left <= r_pix_left - {3'b000, r_len};
                r_state    <= S_CALC;
              end
            end
          end
        end
        S_DRAIN: begin
          // Finish in the cycle the final response is accepted
          if ((r_outstanding == '0) ||
              ((r_outstanding == c_OUT_W'(1)) && w_b_hs)) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outstanding-burst tracker and response acceptance
  always_ff @(posedge ACLK or negedge ARST_N) begin
    if (!ARST_N) begin
      r_outstanding <= '0;
      r_bready      <= 1'b0;
    end else if (RST) begin
      r_outstanding <= '0;
      r_bready      <= 1'b0;
    end else begin
      r_bready <= 1'b1;
      if (w_aw_hs && !w_b_hs) begin
        r_outstanding <= r_outstanding + c_OUT_W'(1);
      end else if (!w_aw_hs && w_b_hs && (r_outstanding != '0)) begin
        r_outstanding <= r_outstanding - c_OUT_W'(1);
      end
    end
  end

`ifdef DRW_WRT_BRESP_ERRCNT_EN
  logic [7:0] r_err_cnt;

  // Saturating count of non-OKAY responses for the current rectangle
  always_ff @(posedge ACLK or negedge ARST_N) begin
    if (!ARST_N) begin
      r_err_cnt <= '0;
    end else if (RST) begin
      r_err_cnt <= '0;
    end else if ((r_state == S_IDLE) && START) begin
      r_err_cnt <= '0;
    end else if (w_b_hs && (M_AXI_BRESP != 2'b00) && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign ERR_CNT = r_err_cnt;
`else
  logic w_unused_bresp;

  assign ERR_CNT        = 8'h00;
  assign w_unused_bresp = ^M_AXI_BRESP;
`endif

endmodule
`default_nettype wire

// File: tb/tb_drw_wrt_burst.sv
`default_nettype none
// ============================================================================
//  Module   : tb_drw_wrt_burst
//  Purpose  : Scoreboard bench for drw_wrt_burst: FIFO model, randomised AXI
//             slave, burst list computed from the rectangle geometry.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_drw_wrt_burst;

  localparam int MAX_BURST = 16;
  localparam int MAX_OUT   = 4;
  localparam int CNT_W     = 9;

  logic             ACLK = 1'b0;
  logic             ARST_N, RST, START;
  logic [31:0]      DST_ADDR;
  logic [15:0]      DST_STRIDE;
  logic [11:0]      WIDTH, HEIGHT;
  logic             BUSY, DONE;
  logic [7:0]       ERR_CNT;
  logic [CNT_W-1:0] WRT_FIFO_DATA_CNT;
  logic             WRT_FIFO_RD;
  logic [31:0]      WRT_FIFO_DOUT;
  logic [31:0]      AWADDR;
  logic [7:0]       AWLEN;
  logic [2:0]       AWSIZE;
  logic [1:0]       AWBURST;
  logic             AWVALID, AWREADY;
  logic [31:0]      WDATA;
  logic [3:0]       WSTRB;
  logic             WLAST, WVALID, WREADY;
  logic [1:0]       BRESP;
  logic             BVALID, BREADY;

  drw_wrt_burst #(.MAX_BURST(MAX_BURST), .MAX_OUTSTANDING(MAX_OUT), .CNT_W(CNT_W)) dut (
    .ACLK(ACLK), .ARST_N(ARST_N), .RST(RST), .START(START),
    .DST_ADDR(DST_ADDR), .DST_STRIDE(DST_STRIDE), .WIDTH(WIDTH), .HEIGHT(HEIGHT),
    .BUSY(BUSY), .DONE(DONE), .ERR_CNT(ERR_CNT),
    .WRT_FIFO_DATA_CNT(WRT_FIFO_DATA_CNT), .WRT_FIFO_RD(WRT_FIFO_RD),
    .WRT_FIFO_DOUT(WRT_FIFO_DOUT),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWLEN(AWLEN), .M_AXI_AWSIZE(AWSIZE),
    .M_AXI_AWBURST(AWBURST), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WLAST(WLAST),
    .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard and bus-model state
  logic [31:0] fifo_q[$];
  logic [31:0] exp_w_q[$];
  logic [31:0] exp_aw_addr[$];
  int          exp_aw_len[$];
  int          wlen_q[$];
  logic [1:0]  b_pend[$];
  logic [1:0]  forced_resp[$];
  int          words_to_push = 0;
  int          cnt_limit     = 511;
  bit          b_enable      = 1'b1;
  bit          rnd_err       = 1'b0;
  bit          mon_en        = 1'b0;
  bit          pop_req       = 1'b0;
  bit          b_hs_flag     = 1'b0;
  bit          in_burst      = 1'b0;
  bit          aw_wait       = 1'b0;
  int          cur_len = 0, beat = 0;
  int          aw_hs_cnt = 0, b_hs_cnt = 0, exp_bursts = 0, done_cnt = 0;
  int          exp_err = 0, last_b_cyc = -10, cyc = 0, awvalid_cycles = 0;
  logic [31:0] prev_awaddr;
  logic [7:0]  prev_awlen;

  task automatic check(input bit ok, input string name, input string detail);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  function automatic int exp_err_val();
`ifdef DRW_WRT_BRESP_ERRCNT_EN
    return (exp_err > 255) ? 255 : exp_err;
`else
    return 0;
`endif
  endfunction

  // Monitor: pops expectations whenever the DUT presents a handshake
  always @(negedge ACLK) begin
    logic [31:0] a, d;
    int          l;
    logic [1:0]  r;
    cyc++;
    pop_req   = 1'b0;
    b_hs_flag = 1'b0;
    if (mon_en) begin
      if (AWVALID) awvalid_cycles++;
      if (aw_wait)
        check(AWVALID && AWADDR == prev_awaddr && AWLEN == prev_awlen, "aw_stable",
              $sformatf("got v=%0b %h/%0d need v=1 %h/%0d", AWVALID, AWADDR, AWLEN, prev_awaddr, prev_awlen));
      aw_wait     = AWVALID && !AWREADY;
      prev_awaddr = AWADDR;
      prev_awlen  = AWLEN;
      if (AWVALID && AWREADY) begin
        aw_hs_cnt++;
        if (exp_aw_addr.size() == 0) begin
          check(1'b0, "aw_unexpected", $sformatf("got %h len %0d need none", AWADDR, AWLEN));
        end else begin
          a = exp_aw_addr.pop_front();
          l = exp_aw_len.pop_front();
          check(AWADDR == a && int'(AWLEN) == l - 1 && AWSIZE == 3'b010 && AWBURST == 2'b01, "aw",
                $sformatf("got %h awlen %0d sz %0d bu %0d need %h awlen %0d sz 2 bu 1",
                          AWADDR, AWLEN, AWSIZE, AWBURST, a, l - 1));
          wlen_q.push_back(l);
        end
      end
      if (WVALID && WREADY) begin
        pop_req = 1'b1;
        if (!in_burst) begin
          cur_len  = (wlen_q.size() > 0) ? wlen_q.pop_front() : 1;
          beat     = 0;
          in_burst = 1'b1;
        end
        d = (exp_w_q.size() > 0) ? exp_w_q.pop_front() : 32'hBAD0_BAD0;
        check(WDATA == d && WLAST == (beat == cur_len - 1) && WSTRB == 4'hF && WRT_FIFO_RD && fifo_q.size() > 0,
              "w_beat", $sformatf("got d=%h last=%0b rd=%0b need d=%h last=%0b rd=1 (beat %0d)",
                                  WDATA, WLAST, WRT_FIFO_RD, d, beat == cur_len - 1, beat));
        beat++;
        if (beat == cur_len) begin
          in_burst = 1'b0;
          if (forced_resp.size() > 0) r = forced_resp.pop_front();
          else r = (rnd_err && $urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
          b_pend.push_back(r);
        end
      end else if (in_burst) begin
        check(WVALID && !WRT_FIFO_RD, "w_continuous", $sformatf("got wvalid=%0b rd=%0b need 1/0", WVALID, WRT_FIFO_RD));
      end
      if (BVALID && BREADY) begin
        b_hs_flag = 1'b1;
        b_hs_cnt++;
        last_b_cyc = cyc;
        if (BRESP != 2'b00) exp_err++;
      end
      if (DONE) begin
        done_cnt++;
        check(b_hs_cnt == exp_bursts && aw_hs_cnt == exp_bursts && last_b_cyc == cyc - 1 &&
              !BUSY && exp_w_q.size() == 0 && words_to_push == 0, "done",
              $sformatf("got b=%0d aw=%0d lag=%0d busy=%0b need b=aw=%0d lag=1 busy=0",
                        b_hs_cnt, aw_hs_cnt, cyc - last_b_cyc, BUSY, exp_bursts));
        check(int'(ERR_CNT) == exp_err_val(), "err_cnt",
              $sformatf("got %0d need %0d", ERR_CNT, exp_err_val()));
      end
    end
  end

  // FIFO producer and randomised AXI slave, updated just after each edge
  always @(posedge ACLK) begin
    int n;
    logic [31:0] d;
    #1;
    if (pop_req && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (b_hs_flag) BVALID = 1'b0;
    if (!BVALID && b_enable && b_pend.size() > 0 && $urandom_range(0, 2) != 0) begin
      BVALID = 1'b1;
      BRESP  = b_pend.pop_front();
    end
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      if (words_to_push > 0 && fifo_q.size() < 500) begin
        d = $urandom;
        fifo_q.push_back(d);
        exp_w_q.push_back(d);
        words_to_push--;
      end
    end
    n = fifo_q.size();
    if (n > cnt_limit) n = cnt_limit;
    WRT_FIFO_DATA_CNT = CNT_W'(n);
    WRT_FIFO_DOUT     = (fifo_q.size() > 0) ? fifo_q[0] : 32'hDEAD_BEEF;
    AWREADY = ($urandom_range(0, 3) != 0);
    WREADY  = ($urandom_range(0, 3) != 0);
  end

  // Reference burst list derived from rectangle geometry
  task automatic build_model(input logic [31:0] addr, input logic [15:0] stride,
                             input int w, input int h, output int nb);
    logic [31:0] base, a;
    int off, room, l;
    nb = 0;
    for (int ln = 0; ln < h; ln++) begin
      base = addr + 32'(ln) * {16'h0000, stride};
      off  = 0;
      while (off < w) begin
        a    = base + 32'(4 * off);
        room = (4096 - int'(a % 32'd4096)) / 4;
        l    = MAX_BURST;
        if (w - off < l) l = w - off;
        if (room < l)    l = room;
        exp_aw_addr.push_back(a);
        exp_aw_len.push_back(l);
        nb++;
        off += l;
      end
    end
  endtask

  task automatic start_rect(input logic [31:0] addr, input logic [15:0] stride,
                            input int w, input int h, input bit preload);
    int nb;
    logic [31:0] d;
    @(posedge ACLK); #2;
    build_model(addr, stride, w, h, nb);
    exp_bursts = nb; aw_hs_cnt = 0; b_hs_cnt = 0; exp_err = 0; awvalid_cycles = 0;
    if (preload) begin
      for (int i = 0; i < w * h; i++) begin
        d = $urandom;
        fifo_q.push_back(d);
        exp_w_q.push_back(d);
      end
    end else begin
      words_to_push += w * h;
    end
    DST_ADDR = addr; DST_STRIDE = stride; WIDTH = 12'(w); HEIGHT = 12'(h);
    START = 1'b1;
    @(posedge ACLK); #2;
    START = 1'b0;
    DST_ADDR = $urandom; WIDTH = 12'd7; HEIGHT = 12'd3;
    @(negedge ACLK);
    check(BUSY == 1'b1, "busy_after_start", $sformatf("got %0b need 1", BUSY));
  endtask

  task automatic wait_done(input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) @(posedge ACLK);
    check(done_cnt != d0, "done_timeout", $sformatf("got no DONE in %0d cycles need DONE", budget));
  endtask

  task automatic flush_tb();
    fifo_q.delete(); exp_w_q.delete(); exp_aw_addr.delete(); exp_aw_len.delete();
    wlen_q.delete(); b_pend.delete(); forced_resp.delete();
    words_to_push = 0; in_burst = 1'b0; aw_wait = 1'b0;
    pop_req = 1'b0; b_hs_flag = 1'b0; BVALID = 1'b0; WRT_FIFO_DATA_CNT = '0;
  endtask

  task automatic check_idle(input string name, input bit exp_bready);
    check(!AWVALID && !WVALID && !WLAST && !BUSY && !DONE && !WRT_FIFO_RD &&
          AWADDR == 32'h0 && AWLEN == 8'h0 && ERR_CNT == 8'h0 && BREADY == exp_bready, name,
          $sformatf("got awv=%0b wv=%0b wl=%0b busy=%0b done=%0b rd=%0b aw=%h len=%0d err=%0d br=%0b need zeros br=%0b",
                    AWVALID, WVALID, WLAST, BUSY, DONE, WRT_FIFO_RD, AWADDR, AWLEN, ERR_CNT, BREADY, exp_bready));
  endtask

  initial begin
    int  w, h;
    bit  seen;
    logic [31:0] a;
    ARST_N = 1'b0; RST = 1'b0; START = 1'b0;
    DST_ADDR = '0; DST_STRIDE = '0; WIDTH = '0; HEIGHT = '0;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
    WRT_FIFO_DATA_CNT = '0; WRT_FIFO_DOUT = '0;
    repeat (3) @(posedge ACLK);
    #3 check_idle("reset_state", 1'b0);
    @(negedge ACLK) ARST_N = 1'b1;
    @(posedge ACLK); #2;
    check(BREADY == 1'b1, "bready_after_reset", $sformatf("got %0b need 1", BREADY));
    mon_en = 1'b1;

    // Single full burst from a preloaded FIFO
    start_rect(32'h1000_0000, 16'h0, 16, 1, 1'b1);
    wait_done(2000);
    // Two lines, each split at the line end
    start_rect(32'h2000_0000, 16'h1000, 20, 2, 1'b0);
    wait_done(3000);
    // 4 KB page split
    start_rect(32'h3000_0FF8, 16'h0, 8, 1, 1'b0);
    wait_done(2000);

    // FIFO occupancy gate
    cnt_limit = 3;
    start_rect(32'h5000_0000, 16'h0, 16, 1, 1'b1);
    repeat (40) @(negedge ACLK);
    check(awvalid_cycles == 0, "aw_gated_by_fifo", $sformatf("got %0d awvalid cycles need 0", awvalid_cycles));
    @(posedge ACLK); #2;
    cnt_limit = 511;
    WRT_FIFO_DATA_CNT = CNT_W'(fifo_q.size());
    seen = 1'b0;
    for (int i = 0; i < 2 && !seen; i++) begin
      @(negedge ACLK);
      seen = AWVALID;
    end
    check(seen, "aw_after_fifo_fill", "got no AWVALID within 2 cycles need AWVALID");
    wait_done(2000);

    // Outstanding limit with responses withheld
    b_enable = 1'b0;
    start_rect(32'h4000_0000, 16'h0, 128, 1, 1'b0);
    repeat (400) @(posedge ACLK);
    check(aw_hs_cnt == MAX_OUT && BUSY, "outstanding_stall",
          $sformatf("got %0d AW busy=%0b need %0d busy=1", aw_hs_cnt, BUSY, MAX_OUT));
    b_enable = 1'b1;
    wait_done(3000);

    // Error responses on 2 of 4 bursts
    forced_resp.push_back(2'b00); forced_resp.push_back(2'b10);
    forced_resp.push_back(2'b00); forced_resp.push_back(2'b10);
    start_rect(32'h6000_0000, 16'h0, 64, 1, 1'b0);
    wait_done(3000);
`ifdef DRW_WRT_BRESP_ERRCNT_EN
    check(ERR_CNT == 8'd2, "err_cnt_two", $sformatf("got %0d need 2", ERR_CNT));
`else
    check(ERR_CNT == 8'd0, "err_cnt_tied", $sformatf("got %0d need 0", ERR_CNT));
`endif

    // Randomised rectangles, some near page ends, random error responses
    rnd_err = 1'b1;
    for (int t = 0; t < 10; t++) begin
      w = $urandom_range(1, 70);
      h = $urandom_range(1, 3);
      a = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if (t % 2 == 0) a = (a & 32'hFFFF_F000) | (32'd4096 - 32'(4 * $urandom_range(1, 40)));
      if (t == 4) begin w = 60; h = 2; end
      start_rect(a, 16'({$urandom_range(0, 16383), 2'b00}), w, h, 1'b0);
      if (t == 4) begin
        // START while busy must be ignored
        repeat (10) @(posedge ACLK);
        #2 DST_ADDR = 32'h0BAD_0000; WIDTH = 12'd5; HEIGHT = 12'd5; START = 1'b1;
        @(posedge ACLK); #2 START = 1'b0;
      end
      wait_done(4000);
    end
    rnd_err = 1'b0;

    // Soft abort mid-burst
    forced_resp.push_back(2'b10); forced_resp.push_back(2'b10);
    forced_resp.push_back(2'b10); forced_resp.push_back(2'b10);
    start_rect(32'h7000_0000, 16'h0, 64, 1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge ACLK);
      seen = WVALID && aw_hs_cnt >= 2;
    end
    check(seen, "rst_reach_burst", "got no second burst need WVALID");
    @(posedge ACLK); #2;
    mon_en = 1'b0; RST = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    check_idle("soft_reset", 1'b0);
    @(posedge ACLK); #2;
    RST = 1'b0;
    flush_tb();
    mon_en = 1'b1;

    // Asynchronous reset mid-burst
    start_rect(32'h7100_0000, 16'h0, 48, 1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge ACLK);
      seen = WVALID && aw_hs_cnt >= 1;
    end
    check(seen, "arst_reach_burst", "got no burst need WVALID");
    @(posedge ACLK); #3;
    mon_en = 1'b0; ARST_N = 1'b0;
    #1 check_idle("async_reset", 1'b0);
    @(posedge ACLK); #2 flush_tb();
    @(negedge ACLK) ARST_N = 1'b1;
    @(posedge ACLK); #2 flush_tb();
    mon_en = 1'b1;

    // Recovery after reset
    start_rect(32'h8000_0FC0, 16'h0100, 24, 2, 1'b0);
    wait_done(3000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
